// File: rtl/mad_pkg.sv
// mad_pkg: shared definitions for the multiply-add forward datapath and its
// sequential inverse.
//   MAD_W        default operand width
//   MAD_RW       result / quotient / remainder width (2 * MAD_W)
//   ERR_Q_FILL   fill bit for the divide-by-zero quotient (all ones at any width)
//   mad_state_t  control states of the inverse block
package mad_pkg;

  localparam int MAD_W  = 8;
  localparam int MAD_RW = 2 * MAD_W;

  // Replicated to the result width so the error quotient stays all ones
  // whatever W the block is built with.
  localparam logic ERR_Q_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mad_state_t;

endpackage

// File: rtl/mad_div_step.sv
// mad_div_step: one combinational restoring-division step.
// Ports:
//   r_in      partial remainder entering the step (always < divisor)
//   next_bit  next dividend bit, shifted in at the LSB
//   divisor   divisor
//   r_out     partial remainder after the step
//   q_bit     quotient bit produced by the step
module mad_div_step
  import mad_pkg::*;
#(
  parameter int RW = MAD_RW
) (
  input  logic [RW-1:0] r_in,
  input  logic          next_bit,
  input  logic [RW-1:0] divisor,
  output logic [RW-1:0] r_out,
  output logic          q_bit
);

  logic [RW:0] r_shift;
  logic [RW:0] r_sub;

  // Because r_in < divisor, the shifted value is below 2*divisor. A trial
  // result below divisor therefore fits in RW bits, and a negative one sets
  // the top bit, so that bit serves directly as the borrow.
  assign r_shift = {r_in, next_bit};
  assign r_sub   = r_shift - {1'b0, divisor};
  assign q_bit   = ~r_sub[RW];
  assign r_out   = q_bit ? r_sub[RW-1:0] : r_shift[RW-1:0];

endmodule

// File: rtl/mad_inverse.sv
// mad_inverse: recovers a from y = a*b*c + d by restoring division,
// one quotient bit per cycle.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (y, b, c, d)
//   out_valid / out_ready result handshake
//   quotient, remainder   recovered a and (y-d) mod (b*c)
//   err_div0              b*c was zero
//   err_under             y was below d
//   busy                  an operation is in flight
module mad_inverse
  import mad_pkg::*;
#(
  parameter int W = MAD_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  y,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    c,
  input  logic [W-1:0]    d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  quotient,
  output logic [2*W-1:0]  remainder,
  output logic            err_div0,
  output logic            err_under,
  output logic            busy
);

  localparam int RW = 2 * W;
  localparam int CW = $clog2(RW);

  mad_state_t state, next_state;

  logic [RW-1:0] y_q;
  logic [W-1:0]  b_q, c_q, d_q;
  logic [RW-1:0] divisor_q;
  logic [RW-1:0] dividend_q;
  logic [RW-1:0] r_q;
  logic [RW-2:0] q_work_q;
  logic [CW-1:0] count_q;
  logic [RW-1:0] quotient_q;
  logic [RW-1:0] remainder_q;
  logic          err_div0_q;
  logic          err_under_q;
  logic          out_valid_q;

  logic [RW-1:0] product;
  logic [RW-1:0] diff;
  logic          y_below_d;
  logic          prod_zero;
  logic          accept;
  logic          out_hs;
  logic          last_step;
  logic [RW-1:0] r_next;
  logic          q_bit;

  assign product   = RW'(b_q) * RW'(c_q);
  assign diff      = y_q - RW'(d_q);
  assign y_below_d = y_q < RW'(d_q);
  assign prod_zero = (product == '0);
  assign accept    = in_valid && (state == ST_IDLE);
  assign out_hs    = out_valid_q && out_ready;
  assign last_step = (count_q == CW'(RW - 1));

  mad_div_step #(.RW(RW)) u_step (
    .r_in     (r_q),
    .next_bit (dividend_q[RW-1]),
    .divisor  (divisor_q),
    .r_out    (r_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_MUL;
      ST_MUL:  next_state = (y_below_d || prod_zero) ? ST_DONE : ST_DIV;
      ST_DIV:  if (last_step) next_state = ST_DONE;
      ST_DONE: if (out_hs) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
  end

  // The result only becomes valid on the cycle after DONE is entered, and a
  // handshake is only possible once it is, so every result is seen for at
  // least one full cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_valid_q <= 1'b0;
    else          out_valid_q <= (state == ST_DONE) && !out_hs;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      divisor_q   <= '0;
      dividend_q  <= '0;
      r_q         <= '0;
      q_work_q    <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      err_div0_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            y_q         <= y;
            b_q         <= b;
            c_q         <= c;
            d_q         <= d;
            err_div0_q  <= 1'b0;
            err_under_q <= 1'b0;
          end
        end
        ST_MUL: begin
          divisor_q  <= product;
          dividend_q <= diff;
          r_q        <= '0;
          q_work_q   <= '0;
          count_q    <= '0;
          // Underflow wins over divide-by-zero for the result values, but
          // both flags are reported.
          if (y_below_d) begin
            err_under_q <= 1'b1;
            err_div0_q  <= prod_zero;
            quotient_q  <= '0;
            remainder_q <= '0;
          end else if (prod_zero) begin
            err_div0_q  <= 1'b1;
            quotient_q  <= {RW{ERR_Q_FILL}};
            remainder_q <= diff;
          end
        end
        ST_DIV: begin
          r_q        <= r_next;
          q_work_q   <= {q_work_q[RW-3:0], q_bit};
          dividend_q <= {dividend_q[RW-2:0], 1'b0};
          count_q    <= count_q + 1'b1;
          if (last_step) begin
            quotient_q  <= {q_work_q, q_bit};
            remainder_q <= r_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign err_div0  = err_div0_q;
  assign err_under = err_under_q;

endmodule

// File: tb/tb_mad_inverse.sv
// tb_mad_inverse: directed and random operand sets for mad_inverse, checked
// against an arithmetic reference model of the inverse.
module tb_mad_inverse;
  import mad_pkg::*;

  localparam int W  = MAD_W;
  localparam int RW = MAD_RW;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] y;
  logic [W-1:0]  b, c, d;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] quotient;
  logic [RW-1:0] remainder;
  logic          err_div0;
  logic          err_under;
  logic          busy;

  int n_checks;
  int n_miscompares;

  mad_inverse #(.W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err_div0  (err_div0),
    .err_under (err_under),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: a = (y - d) / (b*c) in plain integer arithmetic.
  function automatic void model(input int unsigned yv, bv, cv, dv,
                                output int unsigned q, r,
                                output bit e0, eu, output int lat);
    int unsigned bc;
    bc  = bv * cv;
    eu  = (yv < dv);
    e0  = (bc == 0);
    lat = 2;
    if (eu) begin
      q = 0;
      r = 0;
    end else if (e0) begin
      q = (32'd1 << RW) - 1;
      r = yv - dv;
    end else begin
      q   = (yv - dv) / bc;
      r   = (yv - dv) % bc;
      lat = 2 * W + 2;
    end
  endfunction

  task automatic applyStimulus(input int unsigned yv, bv, cv, dv,
                               input bit pre_ready, input int hold);
    int unsigned eq, er;
    bit e0, eu;
    int elat, lat, waits;
    logic [31:0] tmp;
    model(yv, bv, cv, dv, eq, er, e0, eu, elat);
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("in_ready_before_accept", in_ready, 1);
    tmp = yv;
    y = tmp[RW-1:0];
    tmp = bv;
    b = tmp[W-1:0];
    tmp = cv;
    c = tmp[W-1:0];
    tmp = dv;
    d = tmp[W-1:0];
    in_valid  = 1'b1;
    out_ready = pre_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("in_ready_low_after_accept", in_ready, 0);
    checkOutput("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("latency", lat, elat);
    checkOutput("out_valid", out_valid, 1);
    checkOutput("quotient", quotient, eq);
    checkOutput("remainder", remainder, er);
    checkOutput("err_div0", err_div0, e0);
    checkOutput("err_under", err_under, eu);
    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold_out_valid", out_valid, 1);
        checkOutput("hold_quotient", quotient, eq);
        checkOutput("hold_remainder", remainder, er);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("out_valid_after_hs", out_valid, 0);
    checkOutput("in_ready_after_hs", in_ready, 1);
    checkOutput("quotient_kept_after_hs", quotient, eq);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_quotient"}, quotient, 0);
    checkOutput({tag, "_remainder"}, remainder, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_flags"}, {err_div0, err_under}, 0);
  endtask

  initial begin
    int unsigned av, bv, cv, dv, yv;
    int seen;
    n_checks      = 0;
    n_miscompares = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y = '0;
    b = '0;
    c = '0;
    d = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(10, 2, 3, 4, 1'b0, 0);
    applyStimulus(29, 3, 4, 5, 1'b1, 0);
    applyStimulus(66, 4, 5, 6, 1'b1, 0);
    applyStimulus(100, 3, 5, 7, 1'b0, 5);
    applyStimulus(50, 0, 9, 1, 1'b0, 1);
    applyStimulus(3, 2, 2, 4, 1'b0, 0);
    applyStimulus(3, 0, 2, 4, 1'b1, 0);
    applyStimulus(32'hFFFF, 1, 1, 0, 1'b0, 0);
    applyStimulus(100, 3, 5, 7, 1'b0, 0);

    // Abandon an operation part-way through the division.
    y = 16'd1000;
    b = 8'd3;
    c = 8'd7;
    d = 8'd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkResetState("mid_div_reset");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("no_result_after_reset", seen, 0);
    applyStimulus(100, 3, 5, 7, 1'b1, 0);

    for (int n = 0; n < 24; n++) begin
      av = $urandom_range(0, 300);
      bv = $urandom_range(0, 12);
      cv = $urandom_range(1, 20);
      dv = $urandom_range(0, 255);
      yv = (av * bv * cv + dv) & 32'hFFFF;
      if (n % 5 == 4) yv = $urandom_range(0, dv);
      applyStimulus(yv, bv, cv, dv, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule
